uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Parametrised framed-message decoder that sits between the UART receive unloader and the message handler. It consumes one received byte per `rx_valid` strobe and strips SYNC/ESC framing. It validates the byte count and collects up to `MAX_BYTES` payload bytes into a double-buffered output, then pulses `msg_valid`. Over the previous fixed decoder it adds a configurable depth, an enforced timeout, explicit error reporting and an optional checksum.

## Interface
- `MAX_BYTES`, 10, payload capacity in bytes (1..255).
- `TIMEOUT`, 100, `clk` cycles allowed between bytes inside a frame (≥2).
- `SP_SYNC`, 8'h7E, frame start byte.
- `SP_ESC`, 8'hFE, escape byte; the following byte is taken literally.
- `clk`  input  1  single clock; everything is rising-edge.
- `reset`  input  1  asynchronous, active-low; clears all state.
- `rx_byte`  input  8  received byte, valid when `rx_valid` is high.
- `rx_valid`  input  1  one-cycle strobe, at most one byte per cycle.
- `msg_data`  output  MAX_BYTES*8  last good payload; byte 0 is in bits [7:0]; unused bytes are 0.
- `msg_len`  output  8  byte count of the last good payload.
- `msg_valid`  output  1  one-cycle pulse when `msg_data`/`msg_len` update.
- `msg_err`  output  1  one-cycle pulse when a frame is dropped.
- `err_code`  output  2  0=ABORT, 1=BADLEN, 2=TIMEOUT, 3=BADCHK; valid with `msg_err` and held until the next error.
- `busy`  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States are IDLE, BCNT, BODY and CHK. CHK exists only with `FRAME_CHECKSUM_EN`. A separate `esc` flag sits alongside the state.
- Each accepted byte passes through two checks first.
  - Unescaped `SP_ESC`: set `esc`; state is unchanged and no byte is stored.
  - Unescaped `SP_SYNC` in any state: go to BCNT, clear the working buffer and the byte index.
    - If the decoder was in BCNT, BODY or CHK, also pulse `msg_err` with ABORT.
- Otherwise the byte is literal, `esc` is cleared, and the current state handles it:
  - IDLE: discard the byte.
  - BCNT: if the byte is 0 or greater than `MAX_BYTES`, pulse `msg_err` with BADLEN and go to IDLE. Otherwise latch the length and go to BODY.
  - BODY: store at the current index and increment the index. On the final byte go to CHK, or, with no checksum, commit and go to IDLE.
  - CHK: if (len + Σpayload + byte) mod 256 = 0, commit; otherwise pulse `msg_err` with BADCHK. Either way go to IDLE.
- Commit copies the working buffer (with zero-filled tail) and the length to `msg_data`/`msg_len` and pulses `msg_valid`. The outputs hold until the next commit; aborted or errored frames never disturb them.
- Timeout: the counter clears on every `rx_valid` and counts while state ≠ IDLE. When it reaches `TIMEOUT`, pulse `msg_err` with TIMEOUT, go to IDLE and clear `esc`.
- The `esc` flag persists across the timeout only in IDLE; in every other case it is cleared when the frame ends.

## Timing
- Reset values:
  - `msg_data` = 0, `msg_len` = 0, `err_code` = 0.
  - `msg_valid`, `msg_err`, `busy` = 0.
  - State = IDLE, `esc` = 0, counter = 0.
- `msg_valid` and `msg_err` are registered: they rise one cycle after the `rx_valid` edge that completes or kills the frame.
- A frame is N+2 bytes, or N+3 with the checksum. There is no minimum gap between bytes.
- Back-to-back frames: a SYNC arriving in the same cycle as the commit pulse starts the new frame with no loss.
- If `rx_valid` arrives in the cycle the counter would hit `TIMEOUT`, the byte wins: it is processed and the counter clears.
- Asserting `reset` mid-frame drops the frame immediately, with no error pulse.
- The byte index and counter never wrap: the index is bounded by the latched length, and the counter saturates at `TIMEOUT`.

## Configuration
- `FRAME_CHECKSUM_EN`, when defined: CHK state present; each frame carries a trailing checksum byte making (len + payload + chk) mod 256 = 0; BADCHK can occur.
- When not defined: no CHK state; the frame commits after the last payload byte and `err_code` 3 never appears.

## Structure
- Package `uart_frame_pkg` holds:
  - the state encoding;
  - the `err_code` constants (ABORT, BADLEN, TIMEOUT, BADCHK);
  - default `SP_SYNC`/`SP_ESC` values.
- One sub-module, `frame_timer`: a saturating inter-byte counter with a clear input, an enable input and a one-cycle `expired` output, parametrised by `TIMEOUT`.

## Test plan
- Send 7E 03 11 22 33 → `msg_valid` pulse one cycle after the last byte; `msg_len`=3; `msg_data`[23:0]=33_22_11; upper bytes 0.
- Send 7E 02 FE 7E FE FE → payload 7E,FE committed; no ABORT.
- Send 7E 05 AA then 7E 01 55 → ABORT pulse at the second 7E, then commit with `msg_len`=1 and data 55; the earlier good message holds until then.
- Send 7E 00, then 7E 0B (with `MAX_BYTES`=10) → two BADLEN pulses; `msg_data` unchanged.
- Send 7E 04 01 and idle for 100 cycles → TIMEOUT pulse and `busy` falls. Repeat with a byte in cycle 100 → no timeout.
- With `FRAME_CHECKSUM_EN`: 7E 02 10 20 CE → commit; 7E 02 10 20 CF → BADCHK; assert reset mid-frame → all outputs return to 0.

Source files
------------

// File: rtl/uart_frame_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_frame_pkg                                                             |
// | Shared state encoding, error codes and framing defaults for the decoder.   |
// | Optional feature macro: FRAME_CHECKSUM_EN (adds the CHK state).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BCNT = 2'd1,
    ST_BODY = 2'd2
`ifdef FRAME_CHECKSUM_EN
    ,
    ST_CHK  = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    ERR_ABORT   = 2'd0,
    ERR_BADLEN  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_BADCHK  = 2'd3
  } err_t;

  localparam logic [7:0] DEF_SP_SYNC = 8'h7E;
  localparam logic [7:0] DEF_SP_ESC  = 8'hFE;

endpackage

`default_nettype wire

// File: rtl/uart_frame_decoder_if.sv
// +----------------------------------------------------------------------------+
// | uart_frame_decoder_if                                                      |
// | Byte input and message output bundle; master feeds bytes, slave decodes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_frame_decoder_if #(
  parameter int MAX_BYTES = 10
);
  logic [7:0]             rx_byte;
  logic                   rx_valid;
  logic [MAX_BYTES*8-1:0] msg_data;
  logic [7:0]             msg_len;
  logic                   msg_valid;
  logic                   msg_err;
  logic [1:0]             err_code;
  logic                   busy;

  modport master (
    output rx_byte, rx_valid,
    input  msg_data, msg_len, msg_valid, msg_err, err_code, busy
  );

  modport slave (
    input  rx_byte, rx_valid,
    output msg_data, msg_len, msg_valid, msg_err, err_code, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_frame_decoder_timer.sv
// +----------------------------------------------------------------------------+
// | frame_timer                                                                |
// | Saturating inter-byte counter; expired flags the cycle it would hit limit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_timer #(
  parameter int TIMEOUT = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // A same-cycle clear means a byte arrived, and the byte always wins.
  assign expired = en && !clr && (r_cnt == (LIMIT - W'(1)));

endmodule

`default_nettype wire

// File: rtl/uart_frame_decoder.sv
// +----------------------------------------------------------------------------+
// | uart_frame_decoder                                                         |
// | Strips SYNC/ESC framing, validates length and commits payload messages.    |
// | Optional feature macro: FRAME_CHECKSUM_EN (trailing checksum byte).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_BYTES = 10,
  parameter int         TIMEOUT   = 100,
  parameter logic [7:0] SP_SYNC   = DEF_SP_SYNC,
  parameter logic [7:0] SP_ESC    = DEF_SP_ESC
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_frame_decoder_if.slave   bus
);
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  state_t                 r_state;
  err_t                   r_err_code;
  logic                   r_esc;
  logic [7:0]             r_len;
  logic [7:0]             r_idx;
  logic [MAX_BYTES*8-1:0] r_buf;
  logic [MAX_BYTES*8-1:0] r_msg_data;
  logic [7:0]             r_msg_len;
  logic                   r_msg_valid;
  logic                   r_msg_err;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]             r_sum;
`endif

  logic [MAX_BYTES*8-1:0] w_buf_ins;
  logic                   w_last;
  logic                   w_timer_en;
  logic                   w_expired;

  assign w_timer_en = (r_state != ST_IDLE);
  assign w_last     = (r_idx == (r_len - 8'd1));

  // Working buffer with the incoming byte placed at the current index.
  always_comb begin
    w_buf_ins = r_buf;
    w_buf_ins[int'(r_idx)*8 +: 8] = bus.rx_byte;
  end

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (bus.rx_valid),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_err_code  <= ERR_ABORT;
      r_esc       <= 1'b0;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_buf       <= '0;
      r_msg_data  <= '0;
      r_msg_len   <= 8'd0;
      r_msg_valid <= 1'b0;
      r_msg_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_sum       <= 8'd0;
`endif
    end else begin
      r_msg_valid <= 1'b0;
      r_msg_err   <= 1'b0;
      if (bus.rx_valid) begin
        if (!r_esc && (bus.rx_byte == SP_ESC)) begin
          r_esc <= 1'b1;
        end else if (!r_esc && (bus.rx_byte == SP_SYNC)) begin
          if (r_state != ST_IDLE) begin
            r_msg_err  <= 1'b1;
            r_err_code <= ERR_ABORT;
          end
          r_state <= ST_BCNT;
          r_buf   <= '0;
          r_idx   <= 8'd0;
        end else begin
          r_esc <= 1'b0;
          case (r_state)
            ST_IDLE: r_state <= ST_IDLE;
            ST_BCNT: begin
              if ((bus.rx_byte == 8'd0) || (bus.rx_byte > MAX_LEN)) begin
                r_msg_err  <= 1'b1;
                r_err_code <= ERR_BADLEN;
                r_state    <= ST_IDLE;
              end else begin
                r_len   <= bus.rx_byte;
                r_state <= ST_BODY;
`ifdef FRAME_CHECKSUM_EN
                r_sum   <= bus.rx_byte;
`endif
              end
            end
            ST_BODY: begin
              r_buf <= w_buf_ins;
              r_idx <= r_idx + 8'd1;
`ifdef FRAME_CHECKSUM_EN
              r_sum <= r_sum + bus.rx_byte;
              if (w_last) begin
                r_state <= ST_CHK;
              end
`else
              if (w_last) begin
                r_msg_data  <= w_buf_ins;
                r_msg_len   <= r_len;
                r_msg_valid <= 1'b1;
                r_state     <= ST_IDLE;
              end
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHK: begin
              if (8'(r_sum + bus.rx_byte) == 8'd0) begin
                r_msg_data  <= r_buf;
                r_msg_len   <= r_len;
                r_msg_valid <= 1'b1;
              end else begin
                r_msg_err   <= 1'b1;
                r_err_code  <= ERR_BADCHK;
              end
              r_state <= ST_IDLE;
            end
`endif
            default: r_state <= ST_IDLE;
          endcase
        end
      end else if (w_expired) begin
        r_msg_err  <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
        r_state    <= ST_IDLE;
        r_esc      <= 1'b0;
      end
    end
  end

  assign bus.msg_data  = r_msg_data;
  assign bus.msg_len   = r_msg_len;
  assign bus.msg_valid = r_msg_valid;
  assign bus.msg_err   = r_msg_err;
  assign bus.err_code  = r_err_code;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
